// File: rtl/mdr_requester.sv
// mdr_requester: valid/ready host initiator for the multiply/divide/sqrt unit, with hang timeout.
// Define MDR_REQ_STATS_EN to add handoff statistics (stat_ops, stat_errs, stat_clear).
//
// state | meaning
// IDLE  | ready for a command; unit operand registers hold the last op
// FLUSH | one-cycle flush of the unit, operands already presented
// ISSUE | start held until the unit drops ready (busy acknowledge)
// WAIT  | waiting for the unit to raise ready with the result
// RESP  | response presented until the consumer takes it
module mdr_requester #(
  parameter int WORD_LENGTH    = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef MDR_REQ_STATS_EN
  input  logic                   stat_clear,
  output logic [15:0]            stat_ops,
  output logic [15:0]            stat_errs,
`endif
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [WORD_LENGTH-1:0] cmd_x,
  input  logic [WORD_LENGTH-1:0] cmd_y,
  output logic                   mdr_start,
  output logic                   mdr_flush,
  output logic [1:0]             mdr_op,
  output logic [WORD_LENGTH-1:0] mdr_dataX,
  output logic [WORD_LENGTH-1:0] mdr_dataY,
  input  logic                   mdr_ready,
  input  logic [WORD_LENGTH-1:0] mdr_result,
  input  logic [WORD_LENGTH-1:0] mdr_remainder,
  input  logic                   mdr_sign,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_LENGTH-1:0] rsp_result,
  output logic [WORD_LENGTH-1:0] rsp_remainder,
  output logic                   rsp_sign,
  output logic                   rsp_error
);

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [1:0]             op_q;
  logic [WORD_LENGTH-1:0] x_q, y_q;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [WORD_LENGTH-1:0] res_q, rem_q;
  logic                   sign_q, err_q;
  logic                   to_flush;
  logic                   accept, cap_ok, cap_err, timeout, cnt_last;

  // cnt_last marks the final cycle of the ISSUE+WAIT budget
  assign cnt_last = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cap_ok    = 1'b0;
    cap_err   = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_op == 2'b11) begin
            cap_err   = 1'b1;
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (cnt_last) begin
          timeout   = 1'b1;
          cap_err   = 1'b1;
          state_nxt = S_RESP;
        end else if (!mdr_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // completion beats a timeout landing on the same cycle
        if (mdr_ready) begin
          cap_ok    = 1'b1;
          state_nxt = S_RESP;
        end else if (cnt_last) begin
          timeout   = 1'b1;
          cap_err   = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cnt      <= '0;
      res_q    <= '0;
      rem_q    <= '0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
      to_flush <= 1'b0;
    end else begin
      state    <= state_nxt;
      to_flush <= timeout;
      if (accept) begin
        op_q <= cmd_op;
        x_q  <= cmd_x;
        y_q  <= cmd_y;
      end
      if (state == S_FLUSH) begin
        cnt <= '0;
      end else if (state == S_ISSUE || state == S_WAIT) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
      if (cap_ok) begin
        res_q  <= mdr_result;
        rem_q  <= (op_q == 2'b00) ? '0 : mdr_remainder;
        sign_q <= mdr_sign;
        err_q  <= 1'b0;
      end else if (cap_err) begin
        res_q  <= '0;
        rem_q  <= '0;
        sign_q <= 1'b0;
        err_q  <= 1'b1;
      end
    end
  end

  assign cmd_ready     = (state == S_IDLE);
  assign mdr_start     = (state == S_ISSUE);
  assign mdr_flush     = (state == S_FLUSH) || to_flush;
  assign mdr_op        = op_q;
  assign mdr_dataX     = x_q;
  assign mdr_dataY     = y_q;
  assign rsp_valid     = (state == S_RESP);
  assign rsp_result    = res_q;
  assign rsp_remainder = rem_q;
  assign rsp_sign      = sign_q;
  assign rsp_error     = err_q;

`ifdef MDR_REQ_STATS_EN
  logic handoff;
  assign handoff = (state == S_RESP) && rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (stat_clear) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (handoff) begin
      if (err_q) begin
        if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
      end else begin
        if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      end
    end
  end
`endif

endmodule
